// File: rtl/dmem_pkg.sv
// Shared definitions for the RV32I data memory: funct3 encodings, controller
// states and the load-lane extraction/extension helper.
package dmem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic {
        INIT  = 1'b0,
        READY = 1'b1
    } state_t;

    // Selects the addressed byte/halfword of a read word and sign- or zero-extends it.
    function automatic logic [31:0] lane_extract(input logic [31:0] word,
                                                 input logic [1:0]  addr_lo,
                                                 input logic [2:0]  funct3);
        logic [7:0]  b;
        logic [15:0] h;
        b = word[{addr_lo, 3'b000} +: 8];
        h = addr_lo[1] ? word[31:16] : word[15:0];
        case (funct3)
            F3_B:    lane_extract = {{24{b[7]}}, b};
            F3_H:    lane_extract = {{16{h[15]}}, h};
            F3_W:    lane_extract = word;
            F3_BU:   lane_extract = {24'h0, b};
            F3_HU:   lane_extract = {16'h0, h};
            default: lane_extract = 32'h0;
        endcase
    endfunction

endpackage

// File: rtl/dmem_byte_ram.sv
// Word-addressed RAM built from four independent byte lanes; synchronous
// write with per-lane enables and synchronous (read-before-write) read.
module dmem_byte_ram #(
    parameter int DEPTH_WORDS = 1024,
    localparam int AW = $clog2(DEPTH_WORDS)
) (
    input  logic          clk,
    input  logic          en,
    input  logic [3:0]    we,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] mem [DEPTH_WORDS];
            logic [7:0] lane_q;

            always_ff @(posedge clk) begin
                if (en) begin
                    if (we[gi]) begin
                        mem[addr] <= wdata[8*gi +: 8];
                    end
                    lane_q <= mem[addr];
                end
            end

            assign rdata[8*gi +: 8] = lane_q;
        end
    endgenerate

endmodule

// File: rtl/riscv_dmem_ctrl.sv
// RV32I load/store data memory: request decode, fault detection, post-reset
// clear sequencer and a two-stage (RAM read, then extract) response path.
module riscv_dmem_ctrl
    import dmem_pkg::*;
#(
    parameter int          DEPTH_WORDS    = 1024,
    parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
    parameter bit          CLEAR_ON_RESET = 1'b1
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        init_done
);

    localparam int AW = $clog2(DEPTH_WORDS);

    state_t        state_reg;
    logic [AW-1:0] cnt_reg;
    logic          init_done_reg;

    logic          p_valid_reg;
    logic          p_err_reg;
    logic          p_load_reg;
    logic [2:0]    p_funct3_reg;
    logic [1:0]    p_lo_reg;

    logic          rsp_valid_reg;
    logic          rsp_err_reg;
    logic [31:0]   rsp_rdata_reg;

    logic [31:0]   off;
    logic          accept;
    logic          err;
    logic [3:0]    be;
    logic [31:0]   wdata_lanes;

    logic          ram_en;
    logic [3:0]    ram_we;
    logic [AW-1:0] ram_addr;
    logic [31:0]   ram_wdata;
    logic [31:0]   ram_rdata;

    assign req_ready = resetn && (state_reg == READY);
    assign accept    = req_valid && req_ready;
    assign off       = req_addr - BASE_ADDR;

    // Decode: fault detection, byte-lane enables and replicated store data.
    always_comb begin
        err         = (off[31:AW+2] != '0);
        be          = 4'b0000;
        wdata_lanes = req_wdata;
        case (req_funct3)
            F3_B: begin
                be          = 4'b0001 << off[1:0];
                wdata_lanes = {4{req_wdata[7:0]}};
            end
            F3_H: begin
                if (off[0]) err = 1'b1;
                be          = off[1] ? 4'b1100 : 4'b0011;
                wdata_lanes = {2{req_wdata[15:0]}};
            end
            F3_W: begin
                if (off[1:0] != 2'b00) err = 1'b1;
                be = 4'b1111;
            end
            F3_BU: begin
                if (req_we) err = 1'b1;
            end
            F3_HU: begin
                if (req_we || off[0]) err = 1'b1;
            end
            default: err = 1'b1;
        endcase
    end

    always_comb begin
        if (state_reg == INIT) begin
            ram_en    = 1'b1;
            ram_we    = 4'b1111;
            ram_addr  = cnt_reg;
            ram_wdata = 32'h0;
        end else begin
            ram_en    = accept;
            ram_we    = (accept && req_we && !err) ? be : 4'b0000;
            ram_addr  = off[AW+1:2];
            ram_wdata = wdata_lanes;
        end
    end

    dmem_byte_ram #(
        .DEPTH_WORDS(DEPTH_WORDS)
    ) u_ram (
        .clk  (clk),
        .en   (ram_en),
        .we   (ram_we),
        .addr (ram_addr),
        .wdata(ram_wdata),
        .rdata(ram_rdata)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_reg     <= CLEAR_ON_RESET ? INIT : READY;
            cnt_reg       <= '0;
            init_done_reg <= !CLEAR_ON_RESET;
            p_valid_reg   <= 1'b0;
            p_err_reg     <= 1'b0;
            p_load_reg    <= 1'b0;
            p_funct3_reg  <= 3'b000;
            p_lo_reg      <= 2'b00;
            rsp_valid_reg <= 1'b0;
            rsp_err_reg   <= 1'b0;
            rsp_rdata_reg <= 32'h0;
        end else begin
            if (state_reg == INIT) begin
                cnt_reg <= cnt_reg + 1'b1;
                if (cnt_reg == AW'(DEPTH_WORDS - 1)) begin
                    state_reg     <= READY;
                    init_done_reg <= 1'b1;
                end
            end

            // Stage 1 travels alongside the RAM read; stage 2 formats the response.
            p_valid_reg   <= accept;
            p_err_reg     <= err;
            p_load_reg    <= !req_we;
            p_funct3_reg  <= req_funct3;
            p_lo_reg      <= off[1:0];

            rsp_valid_reg <= p_valid_reg;
            rsp_err_reg   <= p_valid_reg && p_err_reg;
            rsp_rdata_reg <= (p_valid_reg && p_load_reg && !p_err_reg)
                             ? lane_extract(ram_rdata, p_lo_reg, p_funct3_reg)
                             : 32'h0;
        end
    end

    assign rsp_valid = rsp_valid_reg;
    assign rsp_err   = rsp_err_reg;
    assign rsp_rdata = rsp_rdata_reg;
    assign init_done = init_done_reg;

endmodule

// File: tb/tb_riscv_dmem_ctrl.sv
// Bench for riscv_dmem_ctrl: byte-array reference model with per-cycle
// comparison, directed literal checks, random traffic and reset disturbances.
module tb_riscv_dmem_ctrl;

    localparam int          DEPTH = 16;
    localparam int          NBYTE = DEPTH * 4;
    localparam logic [31:0] BASE  = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [2:0]  req_funct3 = 3'b000;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        init_done;

    int errors = 0;
    int checks = 0;
    bit run_cmp = 1'b0;

    riscv_dmem_ctrl #(
        .DEPTH_WORDS   (DEPTH),
        .BASE_ADDR     (BASE),
        .CLEAR_ON_RESET(1'b1)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_funct3(req_funct3),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .init_done (init_done)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    typedef struct packed {
        logic        v;
        logic        e;
        logic [31:0] d;
    } rsp_t;

    logic [7:0] bm [NBYTE];
    rsp_t       s1, s2;
    int         cyc;

    function automatic rsp_t model_access(input logic we, input logic [2:0] f3,
                                          input logic [31:0] addr, input logic [31:0] wd);
        rsp_t        r;
        logic [31:0] o;
        int          ob;
        int          size;
        logic [15:0] h;
        o = addr - BASE;
        r.v = 1'b1;
        r.d = 32'h0;
        size = (f3 == 3'd0 || f3 == 3'd4) ? 1 : (f3 == 3'd1 || f3 == 3'd5) ? 2 : 4;
        r.e = (o >= 32'(NBYTE)) || (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7)
              || (we && (f3 == 3'd4 || f3 == 3'd5))
              || ((o % 32'(size)) != 0);
        if (!r.e) begin
            ob = int'(o);
            if (we) begin
                for (int k = 0; k < size; k++) bm[ob + k] = wd[8*k +: 8];
            end else begin
                case (f3)
                    3'd0: r.d = 32'(signed'(bm[ob]));
                    3'd4: r.d = 32'(bm[ob]);
                    3'd1: begin h = {bm[ob+1], bm[ob]}; r.d = 32'(signed'(h)); end
                    3'd5: begin h = {bm[ob+1], bm[ob]}; r.d = 32'(h); end
                    default: r.d = {bm[ob+3], bm[ob+2], bm[ob+1], bm[ob]};
                endcase
            end
        end
        return r;
    endfunction

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            s1  = '0;
            s2  = '0;
            cyc = 0;
            for (int k = 0; k < NBYTE; k++) bm[k] = 8'h00;
        end else begin
            s2 = s1;
            s1 = (req_valid && cyc >= DEPTH)
                 ? model_access(req_we, req_funct3, req_addr, req_wdata) : '0;
            if (cyc < DEPTH) cyc++;
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        logic [35:0] act;
        logic [35:0] expv;
        logic        rdy_e;
        if (run_cmp) begin
            rdy_e = resetn && (cyc >= DEPTH);
            act   = {req_ready, init_done, rsp_valid, rsp_err, rsp_rdata};
            expv  = resetn ? {rdy_e, rdy_e, s2.v, s2.e, s2.d} : 36'h0;
            checks++;
            if (act !== expv) begin
                errors++;
                $display("FAIL cycle_cmp t=%0t: ready/done/valid/err/rdata got %b%b%b%b %h expected %b%b%b%b %h",
                         $time, act[35], act[34], act[33], act[32], act[31:0],
                         expv[35], expv[34], expv[33], expv[32], expv[31:0]);
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    // Called at a negedge; returns at the negedge after the response edge.
    task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wd, output logic vld,
                          output logic [31:0] rd, output logic e);
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wd;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        vld = rsp_valid;
        rd  = rsp_rdata;
        e   = rsp_err;
        $display("req we=%0d f3=%0d addr=%h wdata=%h -> valid=%0d err=%0d rdata=%h",
                 we, f3, addr, wd, vld, e, rd);
    endtask

    task automatic req_chk(input string name, input logic we, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] wd,
                           input logic [31:0] exp_d, input logic exp_e);
        logic        v, e;
        logic [31:0] d;
        do_req(we, f3, addr, wd, v, d, e);
        chk({name, "_valid"}, {31'h0, v}, 32'h1);
        chk({name, "_err"}, {31'h0, e}, {31'h0, exp_e});
        chk({name, "_rdata"}, d, exp_d);
    endtask

    // Releases reset 2 time units after a negedge and counts cycles until ready.
    task automatic release_and_count(input string name);
        int n;
        n = 0;
        @(negedge clk);
        #2 resetn = 1'b1;
        while (n < 100) begin
            @(negedge clk);
            n++;
            if (req_ready) break;
        end
        chk(name, 32'(n), 32'(DEPTH));
        chk({name, "_done"}, {31'h0, init_done}, 32'h1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic        v, e;
        logic [31:0] d;

        repeat (3) @(posedge clk);
        run_cmp = 1'b1;
        @(negedge clk);
        chk("reset_ready", {31'h0, req_ready}, 32'h0);
        chk("reset_rsp_valid", {31'h0, rsp_valid}, 32'h0);
        chk("reset_init_done", {31'h0, init_done}, 32'h0);
        release_and_count("init_cycles");

        for (int w = 0; w < DEPTH; w++)
            req_chk("lw_cleared", 1'b0, 3'd2, 32'(w * 4), 32'h0, 32'h0, 1'b0);

        req_chk("sw_f1", 1'b1, 3'd2, 32'h8, 32'h8000_00F1, 32'h0, 1'b0);
        req_chk("lb_8", 1'b0, 3'd0, 32'h8, 32'h0, 32'hFFFF_FFF1, 1'b0);
        req_chk("lbu_8", 1'b0, 3'd4, 32'h8, 32'h0, 32'h0000_00F1, 1'b0);
        req_chk("lh_a", 1'b0, 3'd1, 32'hA, 32'h0, 32'hFFFF_8000, 1'b0);
        req_chk("lhu_a", 1'b0, 3'd5, 32'hA, 32'h0, 32'h0000_8000, 1'b0);

        req_chk("sw_4", 1'b1, 3'd2, 32'h4, 32'h1122_3344, 32'h0, 1'b0);
        req_chk("sb_5", 1'b1, 3'd0, 32'h5, 32'hFFFF_FFAB, 32'h0, 1'b0);
        req_chk("lw_4_sb", 1'b0, 3'd2, 32'h4, 32'h0, 32'h1122_AB44, 1'b0);
        req_chk("sh_6", 1'b1, 3'd1, 32'h6, 32'h1234_BEEF, 32'h0, 1'b0);
        req_chk("lw_4_sh", 1'b0, 3'd2, 32'h4, 32'h0, 32'hBEEF_AB44, 1'b0);

        req_chk("err_sw_mis", 1'b1, 3'd2, 32'h2, 32'hDEAD_BEEF, 32'h0, 1'b1);
        req_chk("err_lh_mis", 1'b0, 3'd1, 32'h3, 32'h0, 32'h0, 1'b1);
        req_chk("err_f3_011", 1'b0, 3'd3, 32'h4, 32'h0, 32'h0, 1'b1);
        req_chk("err_sw_oor", 1'b1, 3'd2, 32'(NBYTE), 32'hDEAD_BEEF, 32'h0, 1'b1);
        req_chk("err_sbu", 1'b1, 3'd4, 32'h4, 32'hDEAD_BEEF, 32'h0, 1'b1);
        req_chk("lw_0_untouched", 1'b0, 3'd2, 32'h0, 32'h0, 32'h0, 1'b0);
        req_chk("lw_4_untouched", 1'b0, 3'd2, 32'h4, 32'h0, 32'hBEEF_AB44, 1'b0);

        // Back-to-back store then load of the same word.
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'd2;
        req_addr = 32'h10; req_wdata = 32'h1234_5678;
        @(negedge clk);
        req_we = 1'b0; req_wdata = 32'h0;
        @(negedge clk);
        req_valid = 1'b0;
        chk("b2b_sw_valid", {31'h0, rsp_valid}, 32'h1);
        chk("b2b_sw_rdata", rsp_rdata, 32'h0);
        @(negedge clk);
        chk("b2b_lw_valid", {31'h0, rsp_valid}, 32'h1);
        chk("b2b_lw_rdata", rsp_rdata, 32'h1234_5678);
        $display("b2b sw/lw @10 -> rdata=%h", rsp_rdata);

        // Random traffic; the per-cycle compare checks every cycle.
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            req_valid  = ($urandom % 4) != 0;
            req_we     = $urandom % 2;
            req_funct3 = 3'($urandom % 8);
            req_addr   = ($urandom % 10 != 0) ? 32'($urandom_range(0, NBYTE - 1)) : $urandom;
            req_wdata  = $urandom;
        end
        @(negedge clk);
        req_valid = 1'b0;
        repeat (3) @(negedge clk);

        // Reset with a load in flight, then again partway through INIT.
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'd2; req_addr = 32'h10;
        @(posedge clk);
        #2 resetn = 1'b0;
        req_valid = 1'b0;
        @(negedge clk);
        chk("inflight_dropped", {31'h0, rsp_valid}, 32'h0);
        @(negedge clk);
        chk("inflight_dropped2", {31'h0, rsp_valid}, 32'h0);
        @(negedge clk);
        #2 resetn = 1'b1;
        repeat (6) @(negedge clk);
        #2 resetn = 1'b0;
        @(negedge clk);
        chk("midinit_ready", {31'h0, req_ready}, 32'h0);
        release_and_count("reinit_cycles");
        req_chk("lw_10_cleared", 1'b0, 3'd2, 32'h10, 32'h0, 32'h0, 1'b0);
        req_chk("lw_4_cleared", 1'b0, 3'd2, 32'h4, 32'h0, 32'h0, 1'b0);

        do_req(1'b0, 3'd2, 32'h8, 32'h0, v, d, e);
        chk("final_lw_8", d, 32'h0);

        run_cmp = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule

// File: doc/riscv_dmem_ctrl.md
Name: riscv_dmem_ctrl

Overview:
Parametrised, byte-addressable data memory for the RV32I core's load/store stage. It supports all RV32I load/store widths selected by funct3, with byte-lane masking and sign/zero extension. Requests use a valid/ready handshake and read data is registered (one-cycle latency). It flags misaligned, out-of-range and illegal-size accesses, and clears its whole array after reset through an init sequencer.

Parameters:
DEPTH_WORDS, 1024, number of 32-bit words (power of two, >= 2)
BASE_ADDR, 32'h0000_0000, byte address of word 0 (DEPTH_WORDS*4 aligned)
CLEAR_ON_RESET, 1, 1 = run INIT clear after reset; 0 = go straight to READY, array contents undefined

Ports:
clk  in  1  clock, rising edge
resetn  in  1  asynchronous, active-low reset
req_valid  in  1  request present
req_ready  out  1  block accepts a request this cycle
req_we  in  1  1 = store, 0 = load
req_funct3  in  3  RV32I size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
req_addr  in  32  byte address
req_wdata  in  32  store data; low bytes used for B/H
rsp_valid  out  1  response valid, one cycle pulse per accepted request
rsp_rdata  out  32  load result, extended; 0 for stores and errors
rsp_err  out  1  access fault for this response
init_done  out  1  array clear complete

Behaviour:
- Reset (async, resetn=0): state=INIT if CLEAR_ON_RESET else READY. Outputs: req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, init_done=0 (1 if CLEAR_ON_RESET=0), clear counter=0.
- INIT: write 0 to word[cnt] each cycle. cnt increments 0..DEPTH_WORDS-1. On the cycle cnt=DEPTH_WORDS-1 is written, go to READY and set init_done=1 on the next edge. Takes exactly DEPTH_WORDS cycles. req_ready=0 throughout.
- READY: req_ready=1 combinationally. A request is accepted when req_valid && req_ready at the rising edge.
- Offset: off = req_addr - BASE_ADDR (32-bit wrap). Word index = off[log2(DEPTH_WORDS)+1:2].
- Error conditions, any one sets err:
  - off >= DEPTH_WORDS*4 (out of range).
  - H/HU with addr[0]=1.
  - W with addr[1:0]!=0.
  - funct3 in {011,110,111}.
  - Store with funct3 BU/HU (100/101).
- Store, no error: at the accept edge, update only the addressed lanes.
  - SB: lane addr[1:0] <= wdata[7:0].
  - SH: lanes {addr[1],0} and {addr[1],1} <= wdata[15:0].
  - SW: all 4 lanes.
- Store with error: array untouched.
- Load: array read at the accept edge. Lane extraction and extension are registered into rsp_rdata. B/H are sign-extended from bit 7/15; BU/HU are zero-extended.
- Latency: request accepted at edge N gives rsp_valid=1 for exactly one cycle after edge N+1 with rsp_rdata and rsp_err. Back-to-back requests every cycle give back-to-back responses. No response backpressure.
- Same-word ordering: a load accepted the cycle after a store returns the stored data. A store and load cannot coincide (single port).
- rsp_rdata=0 and rsp_err=0 whenever rsp_valid=0.
- Reset mid-operation: any pending response is dropped and INIT restarts from cnt=0.

Decomposition:
- dmem_pkg holds:
  - funct3 localparams: F3_B, F3_H, F3_W, F3_BU, F3_HU.
  - state enum: INIT, READY.
  - function lane_extract(word, addr_lo, funct3) returning 32 bits.
- Sub-module dmem_byte_ram (DEPTH_WORDS x 4 lanes, synchronous write with 4-bit byte enable, synchronous read). Top contains decode, error check, INIT sequencer and response register.

Test Plan:
- Reset with DEPTH_WORDS=16 -> req_ready=0 for 16 cycles, then init_done=1, req_ready=1; LW of every word returns 0.
- SW 0x8000_00F1 @0x8, then LB @0x8 -> 0xFFFF_FFF1; LBU @0x8 -> 0x0000_00F1; LH @0xA -> 0xFFFF_8000; LHU @0xA -> 0x0000_8000; each rsp_valid 1 cycle after accept.
- SB 0xAB @0x5 over word 0x1122_3344 @0x4 -> LW @0x4 = 0x1122_AB44; SH 0xBEEF @0x6 -> LW @0x4 = 0xBEEF_AB44.
- SW @0x2, LH @0x3, funct3=011, SW @DEPTH_WORDS*4 -> each rsp_err=1, rsp_rdata=0, target memory unchanged.
- Back-to-back SW 0x1234_5678 @0x10 then LW @0x10 in consecutive cycles -> second response 0x1234_5678 on consecutive rsp_valid cycles.
- Assert resetn=0 mid-INIT and with a load in flight -> rsp_valid stays 0, INIT restarts, full DEPTH_WORDS-cycle clear observed.
